// File: rtl/dac_playback_ctrl.sv
// dac_playback_ctrl
//  Per-channel playback controller between a waveform FIFO and an RFSoC DAC
//  AXI-Stream port.
//  - Each trigger plays a programmed number of beats.
//  - The first and last beats are lane-masked.
//  - A FIFO underrun is flagged; abort returns the channel to IDLE.
//  - Configuration is serial; shadow registers are copied to the active
//    registers when a trigger is accepted.
//  Optional feature macro: DAC_TRIG_DELAY_EN. It adds a programmable
//  trigger-to-run delay held in the upper bits of MISC.
module dac_playback_ctrl #(
  parameter int DATA_W   = 256,
  parameter int SAMPLE_W = 16,
  parameter int CNT_W    = 32,
  parameter int DLY_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  input  logic              trigger_in,
  input  logic              abort,
  input  logic              cfg_sel,
  input  logic              cfg_shift,
  input  logic [1:0]        cfg_addr,
  input  logic              cfg_sdata,
  output logic              mux_sel,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  localparam int LANES = DATA_W / SAMPLE_W;
`ifdef DAC_TRIG_DELAY_EN
  localparam int MISC_W = 1 + DLY_W;
`else
  localparam int MISC_W = 1;
`endif
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DLY_W-1:0] DLY_ZERO = {DLY_W{1'b0}};
  localparam logic [DLY_W-1:0] DLY_ONE  = {{(DLY_W-1){1'b0}}, 1'b1};
  localparam logic [LANES-1:0] MASK_ALL = {LANES{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;

  // Shadow (serially loaded) configuration
  logic [CNT_W-1:0]   len_sh_r;
  logic [LANES-1:0]   smask_sh_r;
  logic [LANES-1:0]   emask_sh_r;
  logic [MISC_W-1:0]  misc_sh_r;
  logic [DLY_W-1:0]   delay_sh_s;

  // Active playback state
  logic [CNT_W-1:0]   remaining_r;
  logic [LANES-1:0]   smask_act_r;
  logic [LANES-1:0]   emask_act_r;
  logic               first_r;
  logic [DLY_W-1:0]   dly_cnt_r;

  logic               cfg_we_s;
  logic               trig_acc_s;
  logic               run_step_s;
  logic               last_s;
  logic [LANES-1:0]   lane_mask_s;
  logic [DATA_W-1:0]  masked_s;

  assign cfg_we_s   = cfg_sel & cfg_shift;
  assign trig_acc_s = (state_r == ST_IDLE) & trigger_in & ~abort & (len_sh_r != CNT_ZERO);
  assign run_step_s = (state_r == ST_RUN) & m_axis_tready;
  assign last_s     = (remaining_r == CNT_ONE);
  assign mux_sel    = misc_sh_r[0];

  // Without the delay feature the delay field is tied off, so DELAY is
  // unreachable and its counter trims away.
`ifdef DAC_TRIG_DELAY_EN
  assign delay_sh_s = misc_sh_r[DLY_W:1];
`else
  assign delay_sh_s = DLY_ZERO;
`endif

  // Serial configuration: MSB-first shift into the LSB of the addressed register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_sh_r   <= CNT_ZERO;
      smask_sh_r <= {LANES{1'b0}};
      emask_sh_r <= {LANES{1'b0}};
      misc_sh_r  <= {MISC_W{1'b0}};
    end else if (cfg_we_s) begin
      case (cfg_addr)
        2'd0: len_sh_r   <= {len_sh_r[CNT_W-2:0], cfg_sdata};
        2'd1: smask_sh_r <= {smask_sh_r[LANES-2:0], cfg_sdata};
        2'd2: emask_sh_r <= {emask_sh_r[LANES-2:0], cfg_sdata};
        2'd3: begin
`ifdef DAC_TRIG_DELAY_EN
          misc_sh_r <= {misc_sh_r[MISC_W-2:0], cfg_sdata};
`else
          misc_sh_r <= cfg_sdata;
`endif
        end
        default: len_sh_r <= len_sh_r;
      endcase
    end
  end

  // Lane gating of the beat currently offered by the FIFO (first/last masks)
  always_comb begin
    lane_mask_s = (first_r ? smask_act_r : MASK_ALL) & (last_s ? emask_act_r : MASK_ALL);
    masked_s    = {DATA_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if (lane_mask_s[i]) begin
        masked_s[i*SAMPLE_W +: SAMPLE_W] = s_axis_tdata[i*SAMPLE_W +: SAMPLE_W];
      end else begin
        masked_s[i*SAMPLE_W +: SAMPLE_W] = {SAMPLE_W{1'b0}};
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; abort overrides everything, including a trigger
  always_comb begin
    state_nxt_s = state_r;
    if (abort) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (trig_acc_s) begin
            if (delay_sh_s != DLY_ZERO) begin
              state_nxt_s = ST_DELAY;
            end else begin
              state_nxt_s = ST_RUN;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_DELAY: begin
          if (dly_cnt_r == DLY_ONE) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_DELAY;
          end
        end
        ST_RUN: begin
          if (run_step_s && s_axis_tvalid && last_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: FIFO ready follows the DAC only while running
  always_comb begin
    if (state_r == ST_RUN) begin
      s_axis_tready = m_axis_tready;
    end else begin
      s_axis_tready = 1'b0;
    end
    busy = (state_r != ST_IDLE);
  end

  // Playback datapath: counters, active masks, output beat and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_axis_tdata  <= {DATA_W{1'b0}};
      m_axis_tvalid <= 1'b0;
      done          <= 1'b0;
      underrun      <= 1'b0;
      remaining_r   <= CNT_ZERO;
      smask_act_r   <= {LANES{1'b0}};
      emask_act_r   <= {LANES{1'b0}};
      first_r       <= 1'b0;
      dly_cnt_r     <= DLY_ZERO;
    end else begin
      m_axis_tvalid <= 1'b1;
      done          <= 1'b0;
      if (abort) begin
        m_axis_tdata <= {DATA_W{1'b0}};
        first_r      <= 1'b0;
      end else if (trig_acc_s) begin
        remaining_r <= len_sh_r;
        smask_act_r <= smask_sh_r;
        emask_act_r <= emask_sh_r;
        dly_cnt_r   <= delay_sh_s;
        first_r     <= 1'b1;
        underrun    <= 1'b0;
        if (m_axis_tready) begin
          m_axis_tdata <= {DATA_W{1'b0}};
        end
      end else if (run_step_s) begin
        if (s_axis_tvalid) begin
          m_axis_tdata <= masked_s;
          remaining_r  <= remaining_r - CNT_ONE;
          first_r      <= 1'b0;
          done         <= last_s;
        end else begin
          // DAC wants data but FIFO is empty: emit silence, do not count
          m_axis_tdata <= {DATA_W{1'b0}};
          underrun     <= 1'b1;
        end
      end else begin
        if (state_r == ST_DELAY) begin
          dly_cnt_r <= dly_cnt_r - DLY_ONE;
        end
        // Stalled RUN holds the beat; idle/delay output silence
        if (m_axis_tready && (state_r != ST_RUN)) begin
          m_axis_tdata <= {DATA_W{1'b0}};
        end
      end
    end
  end

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Directed self-checking bench for dac_playback_ctrl (default parameters).
module tb_dac_playback_ctrl;

  localparam int DATA_W   = 256;
  localparam int SAMPLE_W = 16;
  localparam int CNT_W    = 32;
  localparam int DLY_W    = 16;
  localparam int LANES    = DATA_W / SAMPLE_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              trigger_in;
  logic              abort;
  logic              cfg_sel;
  logic              cfg_shift;
  logic [1:0]        cfg_addr;
  logic              cfg_sdata;
  logic              mux_sel;
  logic              busy;
  logic              done;
  logic              underrun;

  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   fifo_idx = 0;
  logic pop;

  always #5 clk = ~clk;

  dac_playback_ctrl #(
    .DATA_W(DATA_W), .SAMPLE_W(SAMPLE_W), .CNT_W(CNT_W), .DLY_W(DLY_W)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .trigger_in(trigger_in), .abort(abort),
    .cfg_sel(cfg_sel), .cfg_shift(cfg_shift), .cfg_addr(cfg_addr), .cfg_sdata(cfg_sdata),
    .mux_sel(mux_sel), .busy(busy), .done(done), .underrun(underrun)
  );

  // FIFO word k: lane i holds 16'hA000 + 16*k + i (never zero)
  function automatic logic [DATA_W-1:0] make_beat(input int k);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < LANES; i++) d[i*SAMPLE_W +: SAMPLE_W] = 16'hA000 + 16'(k * 16) + 16'(i);
    return d;
  endfunction

  function automatic logic [DATA_W-1:0] exp_beat(input int k, input logic [LANES-1:0] m);
    logic [DATA_W-1:0] d;
    d = make_beat(k);
    for (int i = 0; i < LANES; i++) if (!m[i]) d[i*SAMPLE_W +: SAMPLE_W] = 16'h0000;
    return d;
  endfunction

  // One clock: handshake judged at negedge, outputs sampled 1 time unit after posedge
  task automatic tick();
    @(negedge clk);
    pop = s_axis_tvalid && s_axis_tready && rst;
    @(posedge clk);
    #1;
    if (pop) begin
      fifo_idx++;
      s_axis_tdata = make_beat(fifo_idx);
    end
  endtask

  task automatic shift_cfg(input logic [1:0] addr, input logic [31:0] val, input int w);
    cfg_sel = 1'b1; cfg_shift = 1'b1; cfg_addr = addr;
    for (int b = w - 1; b >= 0; b--) begin
      cfg_sdata = val[b];
      tick();
    end
    cfg_sel = 1'b0; cfg_shift = 1'b0; cfg_sdata = 1'b0;
  endtask

  task automatic program_ch(input logic [31:0] len, input logic [15:0] sm, input logic [15:0] em);
    shift_cfg(2'd0, len, CNT_W);
    shift_cfg(2'd1, {16'h0000, sm}, LANES);
    shift_cfg(2'd2, {16'h0000, em}, LANES);
  endtask

  task automatic fire();
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1; trigger_in = 1'b0; abort = 1'b0;
    cfg_sel = 1'b0; cfg_shift = 1'b0; cfg_addr = 2'd0; cfg_sdata = 1'b0;
    s_axis_tdata = make_beat(0);
    tick(); tick();
    n_cmp++;
    if ({m_axis_tvalid, s_axis_tready, busy, done, underrun, mux_sel} !== 6'b000000 || m_axis_tdata !== '0) begin
      n_bad++;
      $display("FAIL reset_state got tv=%b tr=%b busy=%b done=%b ur=%b mux=%b data=%h want all 0",
               m_axis_tvalid, s_axis_tready, busy, done, underrun, mux_sel, m_axis_tdata);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (m_axis_tvalid !== 1'b1 || busy !== 1'b0 || m_axis_tdata !== '0) begin
      n_bad++;
      $display("FAIL post_reset got tv=%b busy=%b data=%h want tv=1 busy=0 data=0", m_axis_tvalid, busy, m_axis_tdata);
    end
  endtask

  task automatic test_mux_sel();
    shift_cfg(2'd3, 32'h0000_0001, 1);
    n_cmp++;
    if (mux_sel !== 1'b1) begin
      n_bad++; $display("FAIL mux_sel got %b want 1", mux_sel);
    end
  endtask

  task automatic test_len_zero();
    program_ch(32'd0, 16'hFFFF, 16'hFFFF);
    s_axis_tvalid = 1'b1;
    fire();
    n_cmp++;
    if (busy !== 1'b0 || s_axis_tready !== 1'b0) begin
      n_bad++; $display("FAIL len_zero got busy=%b tready=%b want 0 0", busy, s_axis_tready);
    end
  endtask

  task automatic test_four_beats();
    int base;
    logic [DATA_W-1:0] exp_d;
    program_ch(32'd4, 16'hFFF0, 16'h0FFF);
    s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
    base = fifo_idx;
    fire();
    n_cmp++;
    if ({busy, s_axis_tready, done, underrun} !== 4'b1100) begin
      n_bad++; $display("FAIL four_start got busy/tr/done/ur=%b want 1100", {busy, s_axis_tready, done, underrun});
    end
    trigger_in = 1'b1;  // retrigger while busy must be ignored
    for (int c = 0; c < 5; c++) begin
      tick();
      trigger_in = 1'b0;
      if (c == 0)      exp_d = exp_beat(base, 16'hFFF0);
      else if (c == 3) exp_d = exp_beat(base + 3, 16'h0FFF);
      else if (c == 4) exp_d = '0;
      else             exp_d = exp_beat(base + c, 16'hFFFF);
      n_cmp++;
      if ({m_axis_tdata, done, busy} !== {exp_d, (c == 3), (c < 3)}) begin
        n_bad++;
        $display("FAIL four_beat c=%0d got data=%h done=%b busy=%b want data=%h done=%b busy=%b",
                 c, m_axis_tdata, done, busy, exp_d, (c == 3), (c < 3));
      end
    end
    n_cmp++;
    if (fifo_idx !== base + 4) begin
      n_bad++; $display("FAIL four_pops got %0d want %0d", fifo_idx - base, 4);
    end
  endtask

  task automatic test_single_beat();
    int base;
    program_ch(32'd1, 16'h00FF, 16'hF0FF);
    // unselected shifts must not disturb LEN
    cfg_sel = 1'b0; cfg_shift = 1'b1; cfg_addr = 2'd0; cfg_sdata = 1'b1;
    repeat (4) tick();
    cfg_shift = 1'b0; cfg_sdata = 1'b0;
    base = fifo_idx;
    fire();
    tick();
    // single beat: SMASK & EMASK = 16'h00FF
    n_cmp++;
    if ({m_axis_tdata, done, busy} !== {exp_beat(base, 16'h00FF), 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL single_beat got data=%h done=%b busy=%b want data=%h done=1 busy=0",
               m_axis_tdata, done, busy, exp_beat(base, 16'h00FF));
    end
    tick();
    n_cmp++;
    if (m_axis_tdata !== '0 || done !== 1'b0 || fifo_idx !== base + 1) begin
      n_bad++; $display("FAIL single_after got data=%h done=%b pops=%0d want 0 0 1", m_axis_tdata, done, fifo_idx - base);
    end
  endtask

  task automatic test_underrun();
    int base, j;
    logic v, ed;
    logic [DATA_W-1:0] exp_d;
    program_ch(32'd8, 16'hFFFF, 16'hFFFF);
    base = fifo_idx; j = 0;
    fire();
    for (int c = 0; c < 10; c++) begin
      v = !(c == 3 || c == 4);
      s_axis_tvalid = v;
      tick();
      if (v) begin
        exp_d = exp_beat(base + j, 16'hFFFF);
        j++;
      end else begin
        exp_d = '0;
      end
      ed = v && (j == 8);
      n_cmp++;
      if ({m_axis_tdata, done, underrun} !== {exp_d, ed, (c >= 3)}) begin
        n_bad++;
        $display("FAIL underrun c=%0d got data=%h done=%b ur=%b want data=%h done=%b ur=%b",
                 c, m_axis_tdata, done, underrun, exp_d, ed, (c >= 3));
      end
    end
    s_axis_tvalid = 1'b1;
    tick();
    n_cmp++;
    if (underrun !== 1'b1 || busy !== 1'b0 || fifo_idx !== base + 8) begin
      n_bad++; $display("FAIL underrun_end got ur=%b busy=%b pops=%0d want 1 0 8", underrun, busy, fifo_idx - base);
    end
  endtask

  task automatic test_stall();
    int base, j;
    logic rdy;
    logic [DATA_W-1:0] exp_d;
    base = fifo_idx; j = 0; exp_d = '0;
    fire();  // LEN=8 still programmed
    n_cmp++;
    if (underrun !== 1'b0) begin
      n_bad++; $display("FAIL underrun_clear got %b want 0", underrun);
    end
    for (int c = 0; c < 11; c++) begin
      rdy = !(c >= 3 && c <= 5);
      m_axis_tready = rdy;
      #1;
      n_cmp++;
      if (s_axis_tready !== rdy) begin
        n_bad++; $display("FAIL stall_tready c=%0d got %b want %b", c, s_axis_tready, rdy);
      end
      tick();
      if (rdy) begin
        exp_d = exp_beat(base + j, 16'hFFFF);
        j++;
      end
      n_cmp++;
      if ({m_axis_tdata, done} !== {exp_d, (rdy && j == 8)} || fifo_idx !== base + j) begin
        n_bad++;
        $display("FAIL stall c=%0d got data=%h done=%b pops=%0d want data=%h done=%b pops=%0d",
                 c, m_axis_tdata, done, fifo_idx - base, exp_d, (rdy && j == 8), j);
      end
    end
    m_axis_tready = 1'b1;
  endtask

  task automatic test_abort();
    int base;
    logic [DATA_W-1:0] exp_d;
    logic [15:0] m;
    program_ch(32'd10, 16'hFF00, 16'h00FF);
    base = fifo_idx;
    fire();
    for (int c = 0; c < 4; c++) begin
      abort = (c == 3);
      tick();
      if (c == 3)      exp_d = '0;
      else if (c == 0) exp_d = exp_beat(base, 16'hFF00);
      else             exp_d = exp_beat(base + c, 16'hFFFF);
      n_cmp++;
      if ({m_axis_tdata, done, busy} !== {exp_d, 1'b0, (c < 3)}) begin
        n_bad++;
        $display("FAIL abort c=%0d got data=%h done=%b busy=%b want data=%h done=0 busy=%b",
                 c, m_axis_tdata, done, busy, exp_d, (c < 3));
      end
    end
    // abort wins over a simultaneous trigger
    trigger_in = 1'b1;
    tick();
    abort = 1'b0; trigger_in = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL abort_vs_trig got busy=%b done=%b want 0 0", busy, done);
    end
    base = fifo_idx;
    fire();
    for (int c = 0; c < 10; c++) begin
      tick();
      m = (c == 0) ? 16'hFF00 : ((c == 9) ? 16'h00FF : 16'hFFFF);
      n_cmp++;
      if ({m_axis_tdata, done} !== {exp_beat(base + c, m), (c == 9)}) begin
        n_bad++;
        $display("FAIL replay c=%0d got data=%h done=%b want data=%h done=%b",
                 c, m_axis_tdata, done, exp_beat(base + c, m), (c == 9));
      end
    end
  endtask

`ifdef DAC_TRIG_DELAY_EN
  task automatic test_delay();
    int base;
    program_ch(32'd2, 16'hFFFF, 16'hFFFF);
    shift_cfg(2'd3, 32'h0000_000B, 1 + DLY_W);  // delay=5, mux_sel=1
    base = fifo_idx;
    fire();
    for (int i = 1; i <= 5; i++) begin
      n_cmp++;
      if (busy !== 1'b1 || s_axis_tready !== 1'b0 || m_axis_tdata !== '0) begin
        n_bad++; $display("FAIL delay T+%0d got busy=%b tready=%b want 1 0", i, busy, s_axis_tready);
      end
      tick();
    end
    tick();
    n_cmp++;
    if (m_axis_tdata !== exp_beat(base, 16'hFFFF)) begin
      n_bad++; $display("FAIL delay_first got %h want %h", m_axis_tdata, exp_beat(base, 16'hFFFF));
    end
    tick();
    n_cmp++;
    if ({m_axis_tdata, done} !== {exp_beat(base + 1, 16'hFFFF), 1'b1}) begin
      n_bad++; $display("FAIL delay_last got data=%h done=%b want data=%h done=1", m_axis_tdata, done, exp_beat(base + 1, 16'hFFFF));
    end
  endtask
`endif

  task automatic test_async_reset();
    int base;
    program_ch(32'd8, 16'hFFFF, 16'hFFFF);
    base = fifo_idx;
    fire();
    tick(); tick();
    n_cmp++;
    if (m_axis_tdata !== exp_beat(base + 1, 16'hFFFF) || mux_sel !== 1'b1) begin
      n_bad++; $display("FAIL pre_async got data=%h mux=%b want data=%h mux=1", m_axis_tdata, mux_sel, exp_beat(base + 1, 16'hFFFF));
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({m_axis_tvalid, s_axis_tready, busy, done, underrun, mux_sel} !== 6'b000000 || m_axis_tdata !== '0) begin
      n_bad++;
      $display("FAIL async_reset got tv=%b tr=%b busy=%b done=%b ur=%b mux=%b data=%h want all 0",
               m_axis_tvalid, s_axis_tready, busy, done, underrun, mux_sel, m_axis_tdata);
    end
    #2 rst = 1'b1;
    tick();
    fire();  // LEN was cleared by reset, so this trigger is ignored
    n_cmp++;
    if (busy !== 1'b0 || m_axis_tvalid !== 1'b1) begin
      n_bad++; $display("FAIL post_async got busy=%b tv=%b want busy=0 tv=1", busy, m_axis_tvalid);
    end
  endtask

  initial begin
    test_reset();
    test_mux_sel();
    test_len_zero();
    test_four_beats();
    test_single_beat();
    test_underrun();
    test_stall();
    test_abort();
`ifdef DAC_TRIG_DELAY_EN
    test_delay();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
